// File: rtl/right_shift_seq_if.sv
// Handshake/data bundle between an ALU sequencer and the multi-cycle right shifter.
// The master drives the request side; the slave (the shifter) returns result and flags.
interface right_shift_seq_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
);
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic [AMT_W-1:0] amt;
  logic [1:0]       mode;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;
  logic             busy;
  logic             done;

  modport master (
    output start, data_in, amt, mode,
    input  result, carry, zero, busy, done
  );

  modport slave (
    input  start, data_in, amt, mode,
    output result, carry, zero, busy, done
  );
endinterface

// File: rtl/right_shift_seq.sv
// Multi-cycle right shifter for the 8-bit ALU: one bit per clock in logical,
// arithmetic or rotate mode, with start/busy/done handshake and carry/zero flags.
// Every output comes straight from a register.
module right_shift_seq #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input logic              clk,
  input logic              rst,
  right_shift_seq_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  // Shift count actually performed: rotate wraps modulo WIDTH, the other
  // modes saturate at WIDTH because further shifts cannot change the value.
  function automatic logic [CNT_W-1:0] eff_amount(input logic [AMT_W-1:0] a,
                                                  input logic [1:0]       m);
    logic [31:0] a32;
    a32 = 32'(a);
    if (m == 2'b10) begin
      eff_amount = CNT_W'(a32 % 32'(WIDTH));
    end else if (a32 > 32'(WIDTH)) begin
      eff_amount = CNT_W'(WIDTH);
    end else begin
      eff_amount = CNT_W'(a32);
    end
  endfunction

  state_t           state_r;
  logic [WIDTH-1:0] result_r;
  logic             carry_r;
  logic             zero_r;
  logic             busy_r;
  logic             done_r;
  logic [CNT_W-1:0] count_r;
  logic [1:0]       mode_r;

  logic [CNT_W-1:0] eff_s;
  logic             fill_s;
  logic [WIDTH-1:0] shifted_s;

  assign eff_s = eff_amount(bus.amt, bus.mode);

  // Bit entering at the MSB for the current mode; mode 11 behaves as logical.
  always_comb begin
    fill_s = 1'b0;
    case (mode_r)
      2'b01:   fill_s = result_r[WIDTH-1];
      2'b10:   fill_s = result_r[0];
      default: fill_s = 1'b0;
    endcase
    shifted_s = {fill_s, result_r[WIDTH-1:1]};
  end

  // Control FSM and datapath registers; start is honoured only outside SHIFT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= S_IDLE;
      result_r <= {WIDTH{1'b0}};
      carry_r  <= 1'b0;
      zero_r   <= 1'b1;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      count_r  <= {CNT_W{1'b0}};
      mode_r   <= 2'b00;
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            result_r <= bus.data_in;
            carry_r  <= 1'b0;
            zero_r   <= (bus.data_in == {WIDTH{1'b0}});
            mode_r   <= bus.mode;
            if (eff_s == {CNT_W{1'b0}}) begin
              state_r <= S_DONE;
              count_r <= {CNT_W{1'b0}};
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              state_r <= S_SHIFT;
              count_r <= eff_s;
              busy_r  <= 1'b1;
              done_r  <= 1'b0;
            end
          end else begin
            // No request: results and flags are held for the ALU flag logic.
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
          end
        end
        S_SHIFT: begin
          result_r <= shifted_s;
          carry_r  <= result_r[0];
          zero_r   <= (shifted_s == {WIDTH{1'b0}});
          count_r  <= count_r - CNT_W'(1);
          if (count_r == CNT_W'(1)) begin
            state_r <= S_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            state_r <= S_SHIFT;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.result = result_r;
  assign bus.carry  = carry_r;
  assign bus.zero   = zero_r;
  assign bus.busy   = busy_r;
  assign bus.done   = done_r;

endmodule

// File: tb/tb_right_shift_seq.sv
// Directed bench for right_shift_seq: hand-computed vectors for each mode,
// saturation/wrap boundaries, handshake ordering and asynchronous reset.
module tb_right_shift_seq;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  right_shift_seq_if #(.WIDTH(8), .AMT_W(4)) bus ();

  right_shift_seq #(.WIDTH(8), .AMT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a request at the current negedge; it is captured at the next posedge.
  task automatic launch_now(input logic [7:0] d, input logic [3:0] a, input logic [1:0] m);
    bus.start   = 1'b1;
    bus.data_in = d;
    bus.amt     = a;
    bus.mode    = m;
    @(negedge clk);
    bus.start   = 1'b0;
  endtask

  // Sample once per cycle from the cycle after capture until done (bounded).
  // Optionally pulses a conflicting start after sample number inj.
  task automatic wait_done(input string tag, input int exp_lat, input logic [7:0] exp_res,
                           input logic exp_c, input logic exp_z, input int inj);
    int n;
    int busy_cnt;
    int both;
    logic seen;
    n = 0; busy_cnt = 0; both = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      n++;
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.busy === 1'b1 && bus.done === 1'b1) both++;
      if (bus.done === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (n == inj) begin
          bus.start = 1'b1; bus.data_in = 8'hFF; bus.amt = 4'd1; bus.mode = 2'b10;
        end
        @(negedge clk);
        bus.start = 1'b0;
      end
    end
    check({tag, " done_seen"}, 32'(seen), 32'd1);
    check({tag, " latency"}, 32'(n), 32'(exp_lat));
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(exp_lat - 1));
    check({tag, " busy_and_done"}, 32'(both), 32'd0);
    check({tag, " result"}, 32'(bus.result), 32'(exp_res));
    check({tag, " carry"}, 32'(bus.carry), 32'(exp_c));
    check({tag, " zero"}, 32'(bus.zero), 32'(exp_z));
  endtask

  // One cycle later in IDLE: done has dropped and the result is held.
  task automatic check_after(input string tag, input logic [7:0] exp_res, input logic exp_c);
    @(negedge clk);
    check({tag, " done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, " busy_idle"}, 32'(bus.busy), 32'd0);
    check({tag, " held_result"}, 32'(bus.result), 32'(exp_res));
    check({tag, " held_carry"}, 32'(bus.carry), 32'(exp_c));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.start = 1'b0; bus.data_in = 8'h00; bus.amt = 4'd0; bus.mode = 2'b00;

    // Reset state
    @(negedge clk);
    check("rst result", 32'(bus.result), 32'h00);
    check("rst carry", 32'(bus.carry), 32'd0);
    check("rst zero", 32'(bus.zero), 32'd1);
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst done", 32'(bus.done), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Logical 11001010 >> 3
    launch_now(8'b11001010, 4'd3, 2'b00);
    wait_done("lsr3", 4, 8'b00011001, 1'b0, 1'b0, 0);
    check_after("lsr3", 8'b00011001, 1'b0);

    // Arithmetic 11001010 >> 3
    launch_now(8'b11001010, 4'd3, 2'b01);
    wait_done("asr3", 4, 8'b11111001, 1'b0, 1'b0, 0);
    check_after("asr3", 8'b11111001, 1'b0);

    // Arithmetic saturation: amt 12 -> 8 shifts
    launch_now(8'b10000000, 4'd12, 2'b01);
    wait_done("asr12", 9, 8'b11111111, 1'b1, 1'b0, 0);
    check_after("asr12", 8'b11111111, 1'b1);

    // Rotate by 4
    launch_now(8'b00001111, 4'd4, 2'b10);
    wait_done("ror4", 5, 8'b11110000, 1'b1, 1'b0, 0);
    check_after("ror4", 8'b11110000, 1'b1);

    // Rotate by a multiple of WIDTH -> no shift
    launch_now(8'b00001111, 4'd8, 2'b10);
    wait_done("ror8", 1, 8'b00001111, 1'b0, 1'b0, 0);
    check_after("ror8", 8'b00001111, 1'b0);

    // Rotate by 9 wraps to 1
    launch_now(8'b00000001, 4'd9, 2'b10);
    wait_done("ror9", 2, 8'b10000000, 1'b1, 1'b0, 0);
    check_after("ror9", 8'b10000000, 1'b1);

    // Logical shift to zero
    launch_now(8'b00001111, 4'd4, 2'b00);
    wait_done("lsr4z", 5, 8'h00, 1'b1, 1'b1, 0);
    check_after("lsr4z", 8'h00, 1'b1);

    // Logical amt 0
    launch_now(8'b00001111, 4'd0, 2'b00);
    wait_done("lsr0", 1, 8'b00001111, 1'b0, 1'b0, 0);
    check_after("lsr0", 8'b00001111, 1'b0);

    // Logical saturation amt 15
    launch_now(8'hFF, 4'd15, 2'b00);
    wait_done("lsr15", 9, 8'h00, 1'b1, 1'b1, 0);
    check_after("lsr15", 8'h00, 1'b1);

    // Mode 11 behaves as logical
    launch_now(8'h81, 4'd1, 2'b11);
    wait_done("m11", 2, 8'h40, 1'b1, 1'b0, 0);
    check_after("m11", 8'h40, 1'b1);

    // Start during SHIFT is ignored
    launch_now(8'hF0, 4'd4, 2'b00);
    wait_done("ignore", 5, 8'h0F, 1'b0, 1'b0, 2);
    check_after("ignore", 8'h0F, 1'b0);

    // Back-to-back: new start in the DONE cycle
    launch_now(8'b11001010, 4'd3, 2'b00);
    wait_done("b2b_a", 4, 8'b00011001, 1'b0, 1'b0, 0);
    launch_now(8'b00001111, 4'd4, 2'b10);
    wait_done("b2b_b", 5, 8'b11110000, 1'b1, 1'b0, 0);
    check_after("b2b_b", 8'b11110000, 1'b1);

    // Asynchronous reset mid-SHIFT (logical, amt 7, after 3 shifts)
    launch_now(8'hFF, 4'd7, 2'b00);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("mid busy", 32'(bus.busy), 32'd1);
    check("mid result", 32'(bus.result), 32'h1F);
    rst = 1'b1;
    #1;
    check("arst result", 32'(bus.result), 32'h00);
    check("arst zero", 32'(bus.zero), 32'd1);
    check("arst carry", 32'(bus.carry), 32'd0);
    check("arst busy", 32'(bus.busy), 32'd0);
    check("arst done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst idle done", 32'(bus.done), 32'd0);
    launch_now(8'h81, 4'd1, 2'b00);
    wait_done("post_rst", 2, 8'h40, 1'b1, 1'b0, 0);
    check_after("post_rst", 8'h40, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
